obstacle_ctl: RTL

OBSTACLE_CTL -- requirements
Module: obstacle_ctl

---
 rtl/game_pkg.sv | 21 ++
 rtl/vga_pkg.sv | 7 +
 rtl/obstacle_ctl_if.sv | 23 ++
 rtl/lfsr16.sv | 22 ++
 rtl/obstacle_ctl.sv | 118 +++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Game-wide constants, obstacle FSM state type and gap placement helper.
package game_pkg;

    localparam logic [11:0] OBST_W    = 12'd50;
    localparam logic [11:0] GAP       = 12'd150;
    localparam logic [11:0] MIN_TOP   = 12'd50;
    localparam logic [11:0] RST_TOP   = 12'd200;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    // Low byte of the random word places the top obstacle edge in 50..305.
    function automatic logic [11:0] gap_top(input logic [15:0] rnd);
        return MIN_TOP + {4'd0, rnd[7:0]};
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video timing chain and the game logic.
package vga_pkg;

    localparam logic [11:0] HOR_PIXELS = 12'd800;
    localparam logic [11:0] VER_PIXELS = 12'd600;

endpackage

// File: rtl/obstacle_ctl_if.sv
// Frame/game control inputs and obstacle geometry outputs of obstacle_ctl.
interface obstacle_ctl_if;

    logic        vblnk;
    logic        start;
    logic        collision;
    logic [11:0] obstacle_xpos_1;
    logic [11:0] obstacle_ypos_1;
    logic [11:0] obstacle_ypos_2;
    logic        running;
    logic        passed;

    modport master (
        output vblnk, start, collision,
        input  obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2, running, passed
    );

    modport slave (
        input  vblnk, start, collision,
        output obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2, running, passed
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/obstacle_ctl.sv
// Scrolling obstacle controller: IDLE/RUN/STOP game FSM, one move per vblnk rising edge.
// Optional OBSTACLE_SPEEDUP_EN: step grows by 1 every 8 passes, saturating at 6.
module obstacle_ctl
    import game_pkg::*;
    import vga_pkg::*;
#(
    parameter int unsigned SPEED  = 2,
    parameter int unsigned BIRD_X = 200
) (
    input logic           clk,
    input logic           rst,
    obstacle_ctl_if.slave bus
);

    localparam logic [11:0] BIRD_COL = 12'(BIRD_X);
    localparam logic [11:0] TAIL     = OBST_W - 12'd1;

    state_e      state;
    logic        vblnk_q;
    logic [11:0] x_q;
    logic [11:0] y1_q;
    logic [11:0] y2_q;
    logic        running_q;
    logic        passed_q;
    logic [15:0] rnd;
    logic [11:0] step;
    logic [11:0] x_next;
    logic        tick;
    logic        crossed;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (rnd)
    );

`ifdef OBSTACLE_SPEEDUP_EN
    logic [2:0] speed_q;
    logic [2:0] pass_cnt_q;
    assign step = {9'd0, speed_q};
`else
    assign step = 12'(SPEED);
`endif

    assign tick    = bus.vblnk & ~vblnk_q;
    assign x_next  = x_q - step;
    // Pass = right edge of the obstacle moves from at/after the bird column to before it.
    assign crossed = (x_q + TAIL >= BIRD_COL) && (x_next + TAIL < BIRD_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            vblnk_q   <= 1'b0;
            x_q       <= HOR_PIXELS;
            y1_q      <= RST_TOP;
            y2_q      <= RST_TOP + GAP;
            running_q <= 1'b0;
            passed_q  <= 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
            speed_q    <= 3'(SPEED);
            pass_cnt_q <= 3'd0;
`endif
        end else begin
            vblnk_q  <= bus.vblnk;
            passed_q <= 1'b0;
            case (state)
                StIdle, StStop: begin
                    if (bus.start) begin
                        state     <= StRun;
                        running_q <= 1'b1;
                        x_q       <= HOR_PIXELS;
                        y1_q      <= gap_top(rnd);
                        y2_q      <= gap_top(rnd) + GAP;
`ifdef OBSTACLE_SPEEDUP_EN
                        speed_q    <= 3'(SPEED);
                        pass_cnt_q <= 3'd0;
`endif
                    end
                end
                StRun: begin
                    // Collision wins over start and over the frame tick.
                    if (bus.collision) begin
                        state     <= StStop;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        if (x_q > step) begin
                            x_q      <= x_next;
                            passed_q <= crossed;
`ifdef OBSTACLE_SPEEDUP_EN
                            if (crossed) begin
                                pass_cnt_q <= pass_cnt_q + 3'd1;
                                if (pass_cnt_q == 3'd7 && speed_q < 3'd6) begin
                                    speed_q <= speed_q + 3'd1;
                                end
                            end
`endif
                        end else begin
                            x_q  <= HOR_PIXELS;
                            y1_q <= gap_top(rnd);
                            y2_q <= gap_top(rnd) + GAP;
                        end
                    end
                end
                default: begin
                    state     <= StIdle;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obstacle_xpos_1 = x_q;
    assign bus.obstacle_ypos_1 = y1_q;
    assign bus.obstacle_ypos_2 = y2_q;
    assign bus.running         = running_q;
    assign bus.passed          = passed_q;

endmodule
